// File: rtl/sachen_txc_gen.sv
// sachen_txc_gen: Sachen TXC-style protection mapper.
//
// A small accumulator/input register pair at $4100-$4103 is read back by the
// game as a copy-protection check. A write anywhere in $8000-$FFFF latches the
// accumulator into the output register, which drives the PRG and CHR bank
// selects. An optional alternate CHR register at $4200 and dynamic mirroring
// are selected by parameters.
//
// Ports:
//   clk, reset        - system clock, synchronous active-high reset
//   ce                - M2 CPU-cycle enable
//   enable            - mapper selected
//   flags             - cart flags ([14] static vertical mirroring, [15] CHR RAM)
//   prg_ain/read/write/din - CPU bus
//   prg_dout          - protection read data
//   prg_bus_write     - mapper drives the CPU data bus
//   prg_aout/allow    - PRG address and access permission
//   chr_ain           - PPU address
//   chr_aout/allow    - CHR address and write permission
//   vram_a10, vram_ce - CIRAM control
//   irq               - interrupt request (unused by this board, tied 0)
module sachen_txc_gen #(
    parameter int                REG_W    = 6,
    parameter logic [REG_W-1:0]  INV_MASK = 'h30,
    parameter int                DIN_MODE = 0,
    parameter int                PRG_W    = 2,
    parameter int                PRG_LSB  = 4,
    parameter int                CHR_W    = 4,
    parameter int                CHR_LSB  = 0,
    parameter bit                USE_ALT  = 1'b0,
    parameter bit                MIRR_DYN = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        enable,
    input  logic [31:0] flags,
    input  logic [15:0] prg_ain,
    input  logic        prg_read,
    input  logic        prg_write,
    input  logic [7:0]  prg_din,
    output logic [7:0]  prg_dout,
    output logic        prg_bus_write,
    output logic [21:0] prg_aout,
    output logic        prg_allow,
    input  logic [13:0] chr_ain,
    output logic [21:0] chr_aout,
    output logic        chr_allow,
    output logic        vram_a10,
    output logic        vram_ce,
    output logic        irq
);

    logic [REG_W-1:0] inp;
    logic [REG_W-1:0] acc;
    logic [REG_W-1:0] out_r;
    logic             inv;
    logic             inc;
    logic             dir;
    logic             mir;
    logic [CHR_W-1:0] alt;

    // Board-specific wiring of the CPU data bus onto the protection registers.
    function automatic logic [REG_W-1:0] din_adjust(input logic [7:0] din);
        logic [7:0] t;
        case (DIN_MODE)
            1:       t = din >> 2;
            2:       t = din >> 4;
            3:       t = {2'b00, din[0], din[1], din[2], din[3], din[4], din[5]};
            default: t = din;
        endcase
        return t[REG_W-1:0];
    endfunction

    logic             win_4xxx;
    logic             prot_sel;
    logic             wr_q;
    logic [REG_W-1:0] adj;
    logic [3:0]       acc_step;

    assign win_4xxx = (prg_ain[15:13] == 3'b010);
    assign prot_sel = win_4xxx & prg_ain[8];
    assign wr_q     = enable & ce & prg_write;
    assign adj      = din_adjust(prg_din);
    // 4'hF is -1 modulo 16; the upper accumulator bits never take the carry.
    assign acc_step = acc[3:0] + (dir ? 4'hF : 4'h1);

    always_ff @(posedge clk) begin
        if (reset) begin
            inp   <= '0;
            acc   <= '0;
            out_r <= '0;
            inv   <= 1'b0;
            inc   <= 1'b0;
            dir   <= 1'b0;
            mir   <= 1'b0;
            alt   <= '0;
        end else if (wr_q) begin
            if (prot_sel) begin
                case (prg_ain[1:0])
                    2'd0: begin
                        if (inc)
                            acc[3:0] <= acc_step;
                        else if (inv)
                            acc <= {inp[REG_W-1:4], ~inp[3:0]};
                        else
                            acc <= inp;
                    end
                    2'd1: inv <= adj[0];
                    2'd2: inp <= adj;
                    default: begin
                        inc <= adj[0];
                        dir <= adj[1];
                    end
                endcase
            end
            if (win_4xxx && prg_ain[9])
                alt <= prg_din[CHR_W-1:0];
            // Latches the values as they stood before this write.
            if (prg_ain[15]) begin
                out_r <= acc;
                mir   <= inv;
            end
        end
    end

    logic [CHR_W-1:0] csel;
    logic             mir_sel;

    assign csel    = USE_ALT ? alt : out_r[CHR_LSB +: CHR_W];
    assign mir_sel = MIRR_DYN ? mir : flags[14];

    assign prg_bus_write = enable & prot_sel;
    assign prg_dout      = 8'(acc ^ (inv ? INV_MASK : '0));
    assign prg_allow     = prg_ain[15] & ~prg_write;

    generate
        if (PRG_W > 0) begin : g_prg_bank
            assign prg_aout = (22'(out_r[PRG_LSB +: PRG_W]) << 15) | 22'(prg_ain[14:0]);
        end else begin : g_prg_fixed
            assign prg_aout = 22'(prg_ain[14:0]);
        end
    endgenerate

    assign chr_aout  = 22'h200000 | (22'(csel) << 13) | 22'(chr_ain[12:0]);
    assign chr_allow = flags[15];
    assign vram_ce   = chr_ain[13];
    assign vram_a10  = mir_sel ? chr_ain[10] : chr_ain[11];
    assign irq       = 1'b0;

    logic unused;
    assign unused = &{1'b0, flags[31:16], flags[13:0], prg_read, prg_din};

endmodule

// File: tb/tb_sachen_txc_gen.sv
module tb_sachen_txc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        enable;
    logic [31:0] flags;
    logic [15:0] prg_ain;
    logic        prg_read;
    logic        prg_write;
    logic [7:0]  prg_din;
    logic [13:0] chr_ain;

    logic [7:0]  d0_dout, d1_dout;
    logic        d0_bw, d1_bw;
    logic [21:0] d0_paout, d1_paout;
    logic        d0_pallow, d1_pallow;
    logic [21:0] d0_caout, d1_caout;
    logic        d0_callow, d1_callow;
    logic        d0_a10, d1_a10;
    logic        d0_vce, d1_vce;
    logic        d0_irq, d1_irq;

    always #5 clk = ~clk;

    sachen_txc_gen d0 (
        .clk(clk), .reset(reset), .ce(ce), .enable(enable), .flags(flags),
        .prg_ain(prg_ain), .prg_read(prg_read), .prg_write(prg_write),
        .prg_din(prg_din), .prg_dout(d0_dout), .prg_bus_write(d0_bw),
        .prg_aout(d0_paout), .prg_allow(d0_pallow), .chr_ain(chr_ain),
        .chr_aout(d0_caout), .chr_allow(d0_callow), .vram_a10(d0_a10),
        .vram_ce(d0_vce), .irq(d0_irq)
    );

    sachen_txc_gen #(.DIN_MODE(3), .USE_ALT(1'b1), .MIRR_DYN(1'b1)) d1 (
        .clk(clk), .reset(reset), .ce(ce), .enable(enable), .flags(flags),
        .prg_ain(prg_ain), .prg_read(prg_read), .prg_write(prg_write),
        .prg_din(prg_din), .prg_dout(d1_dout), .prg_bus_write(d1_bw),
        .prg_aout(d1_paout), .prg_allow(d1_pallow), .chr_ain(chr_ain),
        .chr_aout(d1_caout), .chr_allow(d1_callow), .vram_a10(d1_a10),
        .vram_ce(d1_vce), .irq(d1_irq)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    // Pops the oldest expectation and compares it with what the DUT shows.
    task automatic pop_chk(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: got %06h expected none", got);
        end else begin
            e = sb.pop_front();
            chk(e.tag, got, e.val);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        prg_ain   = a;
        prg_din   = d;
        prg_write = 1'b1;
        @(negedge clk);
        prg_write = 1'b0;
        prg_ain   = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_prg(input logic [15:0] a);
        @(negedge clk);
        prg_ain = a;
        #1;
    endtask

    task automatic set_chr(input logic [13:0] a);
        @(negedge clk);
        chr_ain = a;
        #1;
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; enable = 1'b1; flags = 32'h0;
        prg_ain = 16'h0; prg_read = 1'b0; prg_write = 1'b0; prg_din = 8'h0;
        chr_ain = 14'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        push("rst_dout", 32'h00);        set_prg(16'h4100); pop_chk(32'(d0_dout));
        push("rst_busw", 32'h1);         pop_chk(32'(d0_bw));
        push("rst_prg_aout", 32'h0);     set_prg(16'h8000); pop_chk(32'(d0_paout));
        push("rst_chr_aout", 32'h200000); set_chr(14'h0000); pop_chk(32'(d0_caout));
        push("rst_a10_static_h", 32'h1); set_chr(14'h0800); pop_chk(32'(d0_a10));
        push("rst_irq", 32'h0);          pop_chk(32'(d0_irq));

        // Straight load, latch into banks
        wr(16'h4102, 8'h15); wr(16'h4100, 8'h00); wr(16'h8000, 8'h00);
        push("load_dout", 32'h15);       set_prg(16'h4100); pop_chk(32'(d0_dout));
        push("load_prg_aout", 32'h008000); set_prg(16'h8000); pop_chk(32'(d0_paout));
        push("load_chr_aout", 32'h20A000); set_chr(14'h0000); pop_chk(32'(d0_caout));

        // Inverted load and masked read-back
        wr(16'h4101, 8'h01); wr(16'h4102, 8'h15); wr(16'h4100, 8'h00);
        push("inv_dout", 32'h2A);        set_prg(16'h4100); pop_chk(32'(d0_dout));

        // Increment/decrement with 4-bit wrap
        wr(16'h4101, 8'h00); wr(16'h4102, 8'h1F); wr(16'h4100, 8'h00);
        push("acc_1f", 32'h1F);          set_prg(16'h4100); pop_chk(32'(d0_dout));
        wr(16'h4103, 8'h01); wr(16'h4100, 8'h00);
        push("inc_wrap", 32'h10);        set_prg(16'h4100); pop_chk(32'(d0_dout));
        wr(16'h4103, 8'h03); wr(16'h4100, 8'h00);
        push("dec_wrap", 32'h1F);        set_prg(16'h4100); pop_chk(32'(d0_dout));

        // Unqualified writes leave state alone
        ce = 1'b0; wr(16'h4100, 8'h00); ce = 1'b1;
        push("ce0_hold", 32'h1F);        set_prg(16'h4100); pop_chk(32'(d0_dout));
        enable = 1'b0;
        push("en0_busw", 32'h0);         set_prg(16'h4100); pop_chk(32'(d0_bw));
        wr(16'h4100, 8'h00); wr(16'h4103, 8'h00);
        enable = 1'b1;
        push("en0_hold", 32'h1F);        set_prg(16'h4100); pop_chk(32'(d0_dout));

        // Latch 1Fh, static vertical mirroring
        wr(16'h8000, 8'h00);
        flags = 32'h0000_C000;
        push("latch_prg_aout", 32'h008123); set_prg(16'h8123); pop_chk(32'(d0_paout));
        push("latch_chr_aout", 32'h21E005); set_chr(14'h0005); pop_chk(32'(d0_caout));
        push("vert_a10", 32'h1);         set_chr(14'h0400); pop_chk(32'(d0_a10));
        push("chr_allow", 32'h1);        pop_chk(32'(d0_callow));
        push("prg_allow_rd", 32'h1);     set_prg(16'hC000); pop_chk(32'(d0_pallow));
        flags = 32'h0;

        // Reset wins over a coincident qualified write
        @(negedge clk);
        reset = 1'b1; prg_ain = 16'h4102; prg_din = 8'h3F; prg_write = 1'b1;
        @(negedge clk);
        reset = 1'b0; prg_write = 1'b0; prg_ain = 16'h0;
        push("rstw_prg_aout", 32'h004000); set_prg(16'hC000); pop_chk(32'(d0_paout));
        wr(16'h4100, 8'h00);
        push("rstw_inp0", 32'h00);       set_prg(16'h4100); pop_chk(32'(d0_dout));

        // Alternate instance: bit-reversed input, $4200 CHR, dynamic mirroring
        do_reset();
        wr(16'h4102, 8'h01); wr(16'h4100, 8'h00);
        push("rev_inp", 32'h20);         set_prg(16'h4100); pop_chk(32'(d1_dout));
        wr(16'h4200, 8'h03);
        push("alt_chr", 32'h206000);     set_chr(14'h0000); pop_chk(32'(d1_caout));
        // 01h reverses to 20h, so adj[0]=0 and inv stays clear
        wr(16'h4101, 8'h01); wr(16'h8000, 8'h00);
        push("dyn_a10_h", 32'h1);        set_chr(14'h0800); pop_chk(32'(d1_a10));
        // 20h reverses to 01h, setting inv
        wr(16'h4101, 8'h20);
        push("d1_inv_dout", 32'h10);     set_prg(16'h4100); pop_chk(32'(d1_dout));
        push("dyn_pre_latch", 32'h1);    set_chr(14'h0800); pop_chk(32'(d1_a10));
        wr(16'h8000, 8'h00);
        push("dyn_a10_v0", 32'h0);       set_chr(14'h0800); pop_chk(32'(d1_a10));
        push("dyn_a10_v1", 32'h1);       set_chr(14'h0400); pop_chk(32'(d1_a10));

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_left: got %0d expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
